ray_gen_stream: RTL

RAY_GEN_STREAM -- requirements
Module: ray_gen_stream

---
 rtl/ray_gen_pkg.sv | 15 +
 rtl/ray_vec_accum.sv | 22 ++
 rtl/ray_gen_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ray_gen_pkg.sv
// Shared types and default sizes for the ray generator stream.
package ray_gen_pkg;

  localparam int DEF_COORD_W = 11;
  localparam int DEF_DIM_W   = 13;
  localparam int DEF_RAY_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ray_vec_accum.sv
// Three-lane accumulator step: sign-extends each narrow delta lane to the
// accumulator width, then adds it or subtracts it. Results wrap modulo 2^OUT_W.
module ray_vec_accum #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 32
) (
  input  logic [2:0][OUT_W-1:0] acc,
  input  logic [2:0][IN_W-1:0]  delta,
  input  logic                  sub,
  output logic [2:0][OUT_W-1:0] sum
);

  for (genvar i = 0; i < 3; i++) begin : g_lane
    logic signed [IN_W-1:0]  delta_s;
    logic signed [OUT_W-1:0] delta_ext;
    // Sign-extend the lane, then add or subtract it from the accumulator.
    assign delta_s   = delta[i];
    assign delta_ext = OUT_W'(delta_s);
    assign sum[i]    = sub ? (acc[i] - delta_ext) : (acc[i] + delta_ext);
  end

endmodule

// File: rtl/ray_gen_stream.sv
// Streams one camera ray direction per pixel in raster order, using
// incremental adds instead of per-pixel multiplies.
// Optional feature: define RAYGEN_ABORT_EN to add an 'abort' input that
// ends the current frame early.
module ray_gen_stream
  import ray_gen_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int RAY_W   = DEF_RAY_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COORD_W-1:0]   camera_dir_x,
  input  logic [COORD_W-1:0]   camera_dir_y,
  input  logic [COORD_W-1:0]   camera_dir_z,
  input  logic [COORD_W-1:0]   camera_right_x,
  input  logic [COORD_W-1:0]   camera_right_y,
  input  logic [COORD_W-1:0]   camera_right_z,
  input  logic [COORD_W-1:0]   camera_up_x,
  input  logic [COORD_W-1:0]   camera_up_y,
  input  logic [COORD_W-1:0]   camera_up_z,
  input  logic [DIM_W-1:0]     image_width,
  input  logic [DIM_W-1:0]     image_height,
  input  logic                 out_ready,
`ifdef RAYGEN_ABORT_EN
  input  logic                 abort,
`endif
  output logic [RAY_W-1:0]     ray_dir_x,
  output logic [RAY_W-1:0]     ray_dir_y,
  output logic [RAY_W-1:0]     ray_dir_z,
  output logic [2*DIM_W-1:0]   pixel_index,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = 2 * DIM_W;

  state_t state_q, state_d;

  logic [2:0][COORD_W-1:0] dir_q, dir_d, right_q, right_d, up_q, up_d;
  logic [DIM_W-1:0]        w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [2:0][RAY_W-1:0]   cur_q, cur_d, row_q, row_d;
  logic [2:0][RAY_W-1:0]   cur_step, row_step, setup_base;
  logic [RAY_W-1:0]        half_w, half_h;
  logic                    hs, at_row_end, at_last, abort_req;

`ifdef RAYGEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Floor halves of the latched image size, zero-extended to ray width.
  assign half_w = RAY_W'(w_q >> 1);
  assign half_h = RAY_W'(h_q >> 1);

  for (genvar i = 0; i < 3; i++) begin : g_setup
    logic signed [COORD_W-1:0] dir_s, right_s, up_s;
    logic [RAY_W-1:0]          dir_e, right_e, up_e;
    // Top-left ray of the frame: dir - right*(W/2) + up*(H/2), wrapped.
    assign dir_s         = dir_q[i];
    assign right_s       = right_q[i];
    assign up_s          = up_q[i];
    assign dir_e         = RAY_W'(dir_s);
    assign right_e       = RAY_W'(right_s);
    assign up_e          = RAY_W'(up_s);
    assign setup_base[i] = dir_e - (right_e * half_w) + (up_e * half_h);
  end

  // Next ray along the current row.
  ray_vec_accum #(.IN_W(COORD_W), .OUT_W(RAY_W)) u_cur_step (
    .acc   (cur_q),
    .delta (right_q),
    .sub   (1'b0),
    .sum   (cur_step)
  );

  // Start of the next row down.
  ray_vec_accum #(.IN_W(COORD_W), .OUT_W(RAY_W)) u_row_step (
    .acc   (row_q),
    .delta (up_q),
    .sub   (1'b1),
    .sum   (row_step)
  );

  assign at_row_end  = (x_q == (w_q - DIM_W'(1)));
  assign at_last     = at_row_end && (y_q == (h_q - DIM_W'(1)));
  assign out_valid   = (state_q == S_RUN);
  assign out_last    = out_valid && at_last;
  assign hs          = out_valid && out_ready;
  assign busy        = (state_q == S_SETUP) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign pixel_index = idx_q;
  assign ray_dir_x   = cur_q[0];
  assign ray_dir_y   = cur_q[1];
  assign ray_dir_z   = cur_q[2];

  // Frame sequencing: latch on start, set up the first row, step per handshake.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    right_d = right_q;
    up_d    = up_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = {camera_dir_z, camera_dir_y, camera_dir_x};
          right_d = {camera_right_z, camera_right_y, camera_right_x};
          up_d    = {camera_up_z, camera_up_y, camera_up_x};
          w_d     = image_width;
          h_d     = image_height;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort_req || (w_q == '0) || (h_q == '0)) begin
          state_d = S_DONE;
        end else begin
          row_d   = setup_base;
          cur_d   = setup_base;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_req) begin
          state_d = S_DONE;
        end else if (hs) begin
          if (at_last) begin
            state_d = S_DONE;
          end else if (at_row_end) begin
            x_d   = '0;
            y_d   = y_q + DIM_W'(1);
            row_d = row_step;
            cur_d = row_step;
            idx_d = idx_q + IDX_W'(1);
          end else begin
            x_d   = x_q + DIM_W'(1);
            cur_d = cur_step;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      right_q <= '0;
      up_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      right_q <= right_d;
      up_q    <= up_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      row_q   <= row_d;
    end
  end

endmodule
